sr_drive_sequencer: RTL and testbench
=====================================

Name: sr_drive_sequencer

Overview:
- Drives the set/reset excitation pins of an SR storage element, the write side of the SR flip-flop's s/r interface.
- Accepts target-value requests over a valid/ready handshake and buffers them in a small FIFO.
- Emits legal s/r pulses of programmable width and gap, and never drives s=r=1.
- Keeps a shadow copy of the element's state and checks the element's q feedback after every pulse.

Parameters:
- PULSE_CYCLES, 1, cycles s or r is held high per pulse (>=1)
- GAP_CYCLES, 1, cycles s=r=0 after each pulse before q feedback is checked (>=1)
- FIFO_DEPTH, 4, request buffer entries (power of 2, >=2)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted; equals !fifo_full
- req_val  in  1  target q value (1=set, 0=reset)
- req_force  in  1  pulse even if target equals shadow
- s  out  1  registered set excitation
- r  out  1  registered reset excitation
- q_fb  in  1  q feedback from driven element
- q_shadow  out  1  expected element state
- busy  out  1  FSM not IDLE or FIFO non-empty
- err  out  1  sticky feedback-mismatch flag
- err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (async assert, sync-safe deassert use by integrator):
  - s=0, r=0, q_shadow=0 (matches element reset value), err=0.
  - FIFO empty, req_ready=1, busy=0, FSM=IDLE.
- Reset mid-pulse forces s/r low immediately, without waiting for a clock edge.
- Push: on an edge with req_valid&&req_ready, {req_val,req_force} is written. While full, req_ready=0 even if a pop occurs in the same cycle.
- FSM states: IDLE, PULSE, GAP.
- IDLE, FIFO non-empty: pop the head at the next edge.
  - If force or val!=q_shadow: go to PULSE and register s=val, r=~val at that edge.
  - Otherwise: discard the entry (skip) and stay IDLE. Each skip consumes one cycle.
- PULSE: hold s/r for exactly PULSE_CYCLES cycles. At the final edge, s=r=0, q_shadow<=val, go to GAP.
- GAP: s=r=0 for GAP_CYCLES cycles. At the final edge, sample q_fb. If q_fb!=q_shadow, set err=1. Go to IDLE.
- Latency: a request accepted at edge E0 into an empty, idle block raises s/r at E1. s/r fall at E1+PULSE_CYCLES. The check occurs at E1+PULSE_CYCLES+GAP_CYCLES.
- Throughput: one pulse per PULSE_CYCLES+GAP_CYCLES+1 cycles, because IDLE lasts at least one cycle.
- Invariant: s&&r never 1 in any cycle. At most one of s,r is high, and only in PULSE.
- err_clr and a new mismatch on the same edge: err=1 (set wins).
- Counters are sized $clog2(max(PULSE_CYCLES,GAP_CYCLES))+1 and never wrap during a phase.
- FIFO pointers are one bit wider than the address to distinguish full from empty, and wrap modulo 2*FIFO_DEPTH.
- busy=1 while any entry is queued or FSM!=IDLE.

Decomposition:
- Package sr_drive_pkg contains:
  - state enum {IDLE,PULSE,GAP}
  - request struct {val, force}
  - pulse/gap counter width function
- Sub-module sr_req_fifo: synchronous FIFO with parameter FIFO_DEPTH, ports push/pop/full/empty/din/dout, and the same clk/rst_n async reset.

Test Plan:
- Reset: hold rst_n=0 with clocks running -> s=0, r=0, q_shadow=0, err=0, req_ready=1, busy=0. Assert rst_n mid-PULSE -> s drops to 0 with no clock edge.
- Single set, PULSE_CYCLES=2, GAP_CYCLES=1: push val=1 at E0.
  - s=1 for exactly 2 cycles starting E1; r stays 0.
  - q_shadow=1 from E3.
  - q_fb=1 at E4 -> err stays 0.
- Redundant and forced requests:
  - Push val=0 with shadow 0, force=0 -> no pulse, entry consumed in 1 cycle.
  - Same request with force=1 -> r pulses for PULSE_CYCLES.
- Backpressure, FIFO_DEPTH=4: push 6 back-to-back alternating values with the FSM busy.
  - req_ready drops after the 4th entry is stored and stays 0 while the FIFO is full.
  - All accepted entries emerge in order.
  - s/r never both 1.
- Mismatch: tie q_fb=0 and push val=1 -> err=1 after GAP. Pulse err_clr -> err=0. Repeat with err_clr coincident with the next mismatch -> err stays 1.
- Throughput: 4 forced alternating requests with PULSE_CYCLES=1, GAP_CYCLES=2 -> successive pulse starts exactly 4 cycles apart.

Source files
------------

// File: rtl/sr_drive_pkg.sv
// Shared types for the SR excitation sequencer: FSM states, queued request
// format and the pulse/gap counter sizing rule.
package sr_drive_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    // "force" is a reserved word, hence force_en.
    typedef struct packed {
        logic val;
        logic force_en;
    } req_t;

    function automatic int cnt_width(input int pulse_cycles, input int gap_cycles);
        int longest;
        longest = (pulse_cycles > gap_cycles) ? pulse_cycles : gap_cycles;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/sr_req_fifo.sv
// Small synchronous request FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate occupancy counter.
module sr_req_fifo
    import sr_drive_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  req_t din,
    output req_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    req_t          mem_q [FIFO_DEPTH];
    logic          push_en, pop_en;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sr_drive_sequencer.sv
// Drives the s/r excitation pins of an SR storage element from queued
// target-value requests, tracking a shadow state and checking q feedback.
module sr_drive_sequencer
    import sr_drive_pkg::*;
#(
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_val,
    input  logic req_force,
    output logic s,
    output logic r,
    input  logic q_fb,
    output logic q_shadow,
    output logic busy,
    output logic err,
    input  logic err_clr
);

    localparam int            CW         = cnt_width(PULSE_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_q, s_d, r_q, r_d;
    logic          shadow_q, shadow_d;
    logic          val_q, val_d;
    logic          err_q, err_d;

    logic fifo_push, fifo_pop, fifo_full, fifo_empty;
    req_t push_req, head;

    assign push_req  = '{val: req_val, force_en: req_force};
    assign fifo_push = req_valid && req_ready;
    assign req_ready = !fifo_full;

    sr_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_req),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            shadow_q <= 1'b0;
            val_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            r_q      <= r_d;
            shadow_q <= shadow_d;
            val_q    <= val_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        r_d      = r_q;
        shadow_d = shadow_q;
        val_d    = val_q;
        err_d    = err_clr ? 1'b0 : err_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    // Requests that would not change the element are dropped.
                    if (head.force_en || (head.val != shadow_q)) begin
                        state_d = PULSE;
                        cnt_d   = '0;
                        val_d   = head.val;
                        s_d     = head.val;
                        r_d     = !head.val;
                    end
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d  = GAP;
                    cnt_d    = '0;
                    s_d      = 1'b0;
                    r_d      = 1'b0;
                    shadow_d = val_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    // A new mismatch overrides a same-cycle clear.
                    if (q_fb != shadow_q) err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = 1'b0;
                r_d     = 1'b0;
            end
        endcase
    end

    assign s        = s_q;
    assign r        = r_q;
    assign q_shadow = shadow_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Scoreboard bench for sr_drive_sequencer: pulses are predicted at request time
// and matched by monitors; two instances cover both pulse/gap timings.
module tb_sr_drive_sequencer;

    localparam int P1 = 2;
    localparam int G1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic reqValid = 1'b0, reqVal = 1'b0, reqForce = 1'b0, errClr = 1'b0;
    logic reqReady, s, r, qFb, qShadow, busy, err;

    logic reqValid2 = 1'b0, reqVal2 = 1'b0, reqForce2 = 1'b0, errClr2 = 1'b0;
    logic reqReady2, s2, r2, qFb2, qShadow2, busy2, err2;

    logic fbOverride = 1'b0, fbValue = 1'b0;
    logic elemQ, elemQ2;

    int checks = 0;
    int errors = 0;

    logic modelShadow = 1'b0;
    logic expQ[$];
    logic exp2Q[$];

    bit   inPulse = 1'b0;
    int   pulseWidth = 0;
    logic pulseVal = 1'b0;
    logic popped;

    bit   prevHigh2 = 1'b0;
    bit   started2 = 1'b0;
    int   cycleCount = 0;
    int   lastStart2 = 0;
    int   pulses2 = 0;
    logic popped2;

    sr_drive_sequencer #(.PULSE_CYCLES(P1), .GAP_CYCLES(G1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_ready(reqReady),
        .req_val(reqVal), .req_force(reqForce), .s(s), .r(r), .q_fb(qFb),
        .q_shadow(qShadow), .busy(busy), .err(err), .err_clr(errClr)
    );

    sr_drive_sequencer #(.PULSE_CYCLES(1), .GAP_CYCLES(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValid2), .req_ready(reqReady2),
        .req_val(reqVal2), .req_force(reqForce2), .s(s2), .r(r2), .q_fb(qFb2),
        .q_shadow(qShadow2), .busy(busy2), .err(err2), .err_clr(errClr2)
    );

    always #5 clk = ~clk;

    // Behavioural SR elements standing in for the driven flip-flops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) elemQ <= 1'b0;
        else if (s) elemQ <= 1'b1;
        else if (r) elemQ <= 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) elemQ2 <= 1'b0;
        else if (s2) elemQ2 <= 1'b1;
        else if (r2) elemQ2 <= 1'b0;
    end

    assign qFb  = fbOverride ? fbValue : elemQ;
    assign qFb2 = elemQ2;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Issue one request to dut; predicts whether it will produce a pulse.
    task automatic applyStimulus(input logic val, input logic frc, output int stalls);
        stalls   = 0;
        reqVal   = val;
        reqForce = frc;
        reqValid = 1'b1;
        while (!reqReady && stalls < 50) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (!reqReady) begin
            checkOutput("push_timeout", 32'd1, 32'd0);
        end else begin
            if (frc || (val != modelShadow)) expQ.push_back(val);
            modelShadow = val;
            @(posedge clk); #1;
        end
        reqValid = 1'b0;
    endtask

    task automatic applyStimulus2(input logic val);
        reqVal2   = val;
        reqForce2 = 1'b1;
        reqValid2 = 1'b1;
        checkOutput("dut2_ready", reqReady2, 1);
        exp2Q.push_back(val);
        @(posedge clk); #1;
        reqValid2 = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("idle_timeout", busy, 0);
    endtask

    // dut monitor: pulses are compared against the scoreboard once they end.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                inPulse = 1'b0;
                expQ.delete();
            end else begin
                checkOutput("s_r_exclusive", s && r, 0);
                if (s || r) begin
                    if (!inPulse) begin
                        inPulse    = 1'b1;
                        pulseWidth = 1;
                        pulseVal   = s;
                    end else begin
                        pulseWidth++;
                    end
                end else if (inPulse) begin
                    inPulse = 1'b0;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_pulse", 32'd1, 32'd0);
                    end else begin
                        popped = expQ.pop_front();
                        checkOutput("pulse_value", pulseVal, popped);
                        checkOutput("pulse_width", pulseWidth, P1);
                    end
                end
            end
        end
    end

    // dut2 monitor: pulse value and spacing between successive pulse starts.
    initial begin
        forever begin
            @(negedge clk);
            cycleCount++;
            if (!rst_n) begin
                prevHigh2 = 1'b0;
                started2  = 1'b0;
            end else begin
                checkOutput("s2_r2_exclusive", s2 && r2, 0);
                if ((s2 || r2) && !prevHigh2) begin
                    pulses2++;
                    if (exp2Q.size() == 0) begin
                        checkOutput("unexpected_pulse2", 32'd1, 32'd0);
                    end else begin
                        popped2 = exp2Q.pop_front();
                        checkOutput("pulse2_value", s2, popped2);
                    end
                    if (started2) checkOutput("pulse2_spacing", cycleCount - lastStart2, 4);
                    lastStart2 = cycleCount;
                    started2   = 1'b1;
                end
                prevHigh2 = s2 || r2;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int st;
        int n;

        // Reset with the clock running.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_s", s, 0);
        checkOutput("rst_r", r, 0);
        checkOutput("rst_q_shadow", qShadow, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_req_ready", reqReady, 1);
        checkOutput("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Redundant request: consumed in one cycle with no pulse.
        applyStimulus(1'b0, 1'b0, st);
        checkOutput("skip_busy_e0", busy, 1);
        @(posedge clk); #1;
        checkOutput("skip_busy_e1", busy, 0);
        checkOutput("skip_s", s, 0);
        checkOutput("skip_r", r, 0);

        // Same value forced: r pulses.
        applyStimulus(1'b0, 1'b1, st);
        @(posedge clk); #1;
        checkOutput("force_r", r, 1);
        checkOutput("force_s", s, 0);
        waitIdle();
        checkOutput("force_shadow", qShadow, 0);

        // Single set with exact latency.
        applyStimulus(1'b1, 1'b0, st);
        checkOutput("set_s_e0", s, 0);
        @(posedge clk); #1;
        checkOutput("set_s_e1", s, 1);
        checkOutput("set_r_e1", r, 0);
        @(posedge clk); #1;
        checkOutput("set_s_e2", s, 1);
        checkOutput("set_shadow_e2", qShadow, 0);
        @(posedge clk); #1;
        checkOutput("set_s_e3", s, 0);
        checkOutput("set_shadow_e3", qShadow, 1);
        checkOutput("set_busy_gap", busy, 1);
        @(posedge clk); #1;
        checkOutput("set_err_e4", err, 0);
        checkOutput("set_busy_e4", busy, 0);

        // Backpressure: six alternating requests while the FSM is busy.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(logic'(i % 2), 1'b0, st);
            checkOutput("bp_no_stall", st, 0);
        end
        checkOutput("bp_ready_full", reqReady, 0);
        checkOutput("bp_busy", busy, 1);
        applyStimulus(1'b1, 1'b0, st);
        checkOutput("bp_stall_cycles", st, 1);
        waitIdle();
        checkOutput("bp_err", err, 0);
        checkOutput("bp_shadow", qShadow, modelShadow);
        checkOutput("bp_drained", expQ.size(), 0);

        // Feedback mismatch, clear, then clear coinciding with a new mismatch.
        fbOverride = 1'b1;
        fbValue    = 1'b0;
        applyStimulus(1'b1, 1'b1, st);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("mm_err_before", err, 0);
        @(posedge clk); #1;
        checkOutput("mm_err_set", err, 1);
        errClr = 1'b1;
        @(posedge clk); #1;
        errClr = 1'b0;
        checkOutput("mm_err_cleared", err, 0);
        fbValue = 1'b1;
        applyStimulus(1'b0, 1'b0, st);
        errClr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("mm_err_held_clear", err, 0);
        @(posedge clk); #1;
        checkOutput("mm_set_wins", err, 1);
        errClr = 1'b0;
        fbOverride = 1'b0;
        errClr = 1'b1;
        @(posedge clk); #1;
        errClr = 1'b0;
        waitIdle();
        checkOutput("sb_dut_empty", expQ.size(), 0);

        // Throughput on dut2: four forced alternating requests back to back.
        applyStimulus2(1'b1);
        applyStimulus2(1'b0);
        applyStimulus2(1'b1);
        applyStimulus2(1'b0);
        n = 0;
        while (busy2 === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("dut2_idle", busy2, 0);
        checkOutput("dut2_pulse_count", pulses2, 4);
        checkOutput("dut2_sb_empty", exp2Q.size(), 0);
        checkOutput("dut2_err", err2, 0);

        // Reset in the middle of a pulse drops s with no clock edge.
        applyStimulus(1'b1, 1'b1, st);
        @(posedge clk); #1;
        checkOutput("midrst_s_before", s, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_s", s, 0);
        checkOutput("midrst_r", r, 0);
        checkOutput("midrst_shadow", qShadow, 0);
        checkOutput("midrst_busy", busy, 0);
        modelShadow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
